mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline, between execute and write-back.
- Accepts one instruction per handshake from the EX/MEM boundary. Issues loads and stores to the data-memory port using a valid/ready request channel and a valid response channel.
- Performs load sign/zero extension and store byte-lane steering.
- Registers the MEM/WB bundle (alu_result, read_data, pc_plus_4, pc_plus_imm, result_src, rd, reg_write) consumed by the write-back stage.

Parameters:
- XLEN, 32, data/address width (taken from `XLEN).
- RSB, 2, result-source select width (taken from `RESULT_SRC_BITS_COUNT).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM bundle valid.
- in_stall  out  1  high: stage cannot accept; upstream holds its bundle.
- in_alu_result  in  XLEN  ALU result; also the effective address.
- in_store_data  in  XLEN  rs2 value for stores.
- in_funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store (never together with in_mem_read).
- in_pc_plus_4, in_pc_plus_imm  in  XLEN  passthrough.
- in_result_src  in  RSB  passthrough.
- in_rd  in  5  destination register.
- in_reg_write  in  1  register write enable.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  XLEN  word-aligned address, bits [1:0] = 0.
- mem_req_we  out  1  store.
- mem_req_be  out  4  byte enables.
- mem_req_wdata  out  XLEN  lane-steered store data.
- mem_rsp_valid  in  1  response (load data or store ack).
- mem_rsp_rdata  in  XLEN  raw word read.
- wb_valid  out  1  MEM/WB bundle valid (one-cycle pulse per instruction).
- wb_alu_result, wb_read_data, wb_pc_plus_4, wb_pc_plus_imm  out  XLEN  to write-back.
- wb_result_src  out  RSB  to write-back.
- wb_rd  out  5  to write-back.
- wb_reg_write  out  1  to write-back.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - State goes to IDLE.
  - mem_req_valid, wb_valid, wb_reg_write = 0; all wb_* data = 0.
  - mem_req_* data = 0.
  - Any in-flight request is abandoned; a late mem_rsp_valid is ignored until a new request is issued.
- FSM states: IDLE, REQ, WAIT, plus RESP (see Optional Feature).
- in_stall = (state != IDLE).
- Accept occurs when in_valid && !in_stall. Bundle is captured into holding registers.
- Non-memory op accepted in cycle N: wb_* reflect the bundle in N+1, wb_valid=1, wb_read_data=0. State stays IDLE, giving one instruction per cycle throughput.
- Memory op accepted in N: state goes to REQ at N+1.
  - REQ: mem_req_valid=1 and mem_req_* are stable until mem_req_ready. On handshake, state goes to WAIT.
  - WAIT: on mem_rsp_valid, capture and extend read data. In the next cycle, wb_valid=1 and state returns to IDLE.
  - A response arriving in the same cycle as the request handshake is not allowed; the earliest response is the cycle after.
  - Minimum load/store latency: accept to wb_valid = 3 cycles.
- wb_valid is 0 in every cycle not listed above. wb_* hold their last values when wb_valid=0.
- Load extension uses a = addr[1:0]:
  - B: sign-extend byte a.
  - BU: zero-extend byte a.
  - H: sign-extend halfword a[1].
  - HU: zero-extend halfword a[1].
  - W: full word.
  - Unlisted funct3: result 0.
- Stores:
  - be: B = 0001<<a; H = 0011<<(2*a[1]); W = 1111.
  - wdata: byte/half replicated across lanes.
  - Loads drive be = 1111, we = 0.
- in_mem_read and in_mem_write both high: treated as a non-memory op (no request issued).

Optional Feature:
- MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output wb_misaligned (1 bit, reset 0).
  - H/HU/SH with a[0]=1, or W/SW with a!=0, issues no request. State goes IDLE to RESP.
  - RESP: next cycle wb_valid=1, wb_misaligned=1, wb_reg_write=0, then back to IDLE.
  - Accept-to-wb latency is 2 cycles.
- Undefined:
  - No port and no RESP state.
  - Misaligned accesses proceed using the truncated lane select above (halfword uses a[1]; word ignores a).

Test Plan:
- Reset: rst_n low mid-WAIT -> mem_req_valid=0, wb_valid=0, in_stall=0 immediately. A stale mem_rsp_valid after release produces no wb_valid.
- ALU op stream: 3 back-to-back accepts with alu_result 1,2,3 -> wb_valid high on 3 consecutive cycles with wb_alu_result 1,2,3. in_stall stays 0.
- LB from addr 0x103, rdata 0x80FF_1234 -> be=1111, addr 0x100, wb_read_data 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH to 0x202, data 0x0000_ABCD, mem_req_ready held low 4 cycles -> request stable for all 5 cycles, be=1100, wdata 0xABCD_ABCD, in_stall=1 until wb_valid.
- LW with response 5 cycles after handshake -> wb_valid exactly once, one cycle after mem_rsp_valid, with wb_read_data = rdata, and wb_rd/wb_result_src preserved.
- MEM_MISALIGN_TRAP_EN: LW at 0x301 -> no mem_req_valid; wb_valid 2 cycles after accept with wb_misaligned=1, wb_reg_write=0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: valid/ready request channel plus a valid-only response.
// The stage drives the master side; the data memory drives the slave side.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_access_stage_if #(
   parameter int XLEN = `XLEN
);
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_req_addr;
   logic            mem_req_we;
   logic [3:0]      mem_req_be;
   logic [XLEN-1:0] mem_req_wdata;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_rdata;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      output mem_req_we,
      output mem_req_be,
      output mem_req_wdata,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      input  mem_req_we,
      input  mem_req_be,
      input  mem_req_wdata,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: load/store issue, lane steering, load extension, MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses via wb_misaligned.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RESULT_SRC_BITS_COUNT
`define RESULT_SRC_BITS_COUNT 2
`endif

module mem_access_stage #(
   parameter int XLEN = `XLEN,
   parameter int RSB  = `RESULT_SRC_BITS_COUNT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_stall,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [2:0]      in_funct3,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic [XLEN-1:0] in_pc_plus_4,
   input  logic [XLEN-1:0] in_pc_plus_imm,
   input  logic [RSB-1:0]  in_result_src,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   mem_access_stage_if.master mem,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_alu_result,
   output logic [XLEN-1:0] wb_read_data,
   output logic [XLEN-1:0] wb_pc_plus_4,
   output logic [XLEN-1:0] wb_pc_plus_imm,
   output logic [RSB-1:0]  wb_result_src,
   output logic [4:0]      wb_rd,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic            wb_misaligned,
`endif
   output logic            wb_reg_write
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
`ifdef MEM_MISALIGN_TRAP_EN
      , S_RESP
`endif
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_alu;
   logic [XLEN-1:0] r_pc4;
   logic [XLEN-1:0] r_pcimm;
   logic [RSB-1:0]  r_rsrc;
   logic [4:0]      r_rd;
   logic            r_regw;
   logic            r_we;
   logic [2:0]      r_f3;
   logic [1:0]      r_a;

   logic            w_is_mem;
   logic [1:0]      w_a;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata;

   assign in_stall = (r_state != S_IDLE);
   assign w_is_mem = in_mem_read ^ in_mem_write;
   assign w_a      = in_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   logic w_mis;
   always_comb begin
      w_mis = 1'b0;
      case (in_funct3)
         3'b001:  w_mis = w_a[0];
         3'b101:  w_mis = w_a[0] && in_mem_read;
         3'b010:  w_mis = (w_a != 2'b00);
         default: w_mis = 1'b0;
      endcase
   end
`endif

   // Loads always fetch the whole word; lane selection happens on return.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = '0;
      if (in_mem_read) begin
         w_be = 4'b1111;
      end else begin
         case (in_funct3)
            3'b000: begin
               w_be    = 4'b0001 << w_a;
               w_wdata = {4{in_store_data[7:0]}};
            end
            3'b001: begin
               w_be    = w_a[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{in_store_data[15:0]}};
            end
            3'b010: begin
               w_be    = 4'b1111;
               w_wdata = in_store_data;
            end
            default: begin
               w_be    = 4'b0000;
               w_wdata = '0;
            end
         endcase
      end
   end

   function automatic logic [XLEN-1:0] f_ext(
      input logic [2:0]      i_f3,
      input logic [1:0]      i_a,
      input logic [XLEN-1:0] i_d
   );
      logic [7:0]  v_b;
      logic [15:0] v_h;
      v_b = 8'(i_d >> {i_a, 3'b000});
      v_h = i_a[1] ? i_d[31:16] : i_d[15:0];
      case (i_f3)
         3'b000:  f_ext = {{(XLEN-8){v_b[7]}}, v_b};
         3'b100:  f_ext = {{(XLEN-8){1'b0}}, v_b};
         3'b001:  f_ext = {{(XLEN-16){v_h[15]}}, v_h};
         3'b101:  f_ext = {{(XLEN-16){1'b0}}, v_h};
         3'b010:  f_ext = i_d;
         default: f_ext = '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state            <= S_IDLE;
         r_alu              <= '0;
         r_pc4              <= '0;
         r_pcimm            <= '0;
         r_rsrc             <= '0;
         r_rd               <= '0;
         r_regw             <= 1'b0;
         r_we               <= 1'b0;
         r_f3               <= '0;
         r_a                <= '0;
         mem.mem_req_valid  <= 1'b0;
         mem.mem_req_addr   <= '0;
         mem.mem_req_we     <= 1'b0;
         mem.mem_req_be     <= '0;
         mem.mem_req_wdata  <= '0;
         wb_valid           <= 1'b0;
         wb_alu_result      <= '0;
         wb_read_data       <= '0;
         wb_pc_plus_4       <= '0;
         wb_pc_plus_imm     <= '0;
         wb_result_src      <= '0;
         wb_rd              <= '0;
         wb_reg_write       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         wb_misaligned      <= 1'b0;
`endif
      end else begin
         wb_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_alu   <= in_alu_result;
                  r_pc4   <= in_pc_plus_4;
                  r_pcimm <= in_pc_plus_imm;
                  r_rsrc  <= in_result_src;
                  r_rd    <= in_rd;
                  r_regw  <= in_reg_write;
                  r_we    <= in_mem_write;
                  r_f3    <= in_funct3;
                  r_a     <= w_a;
                  if (!w_is_mem) begin
                     wb_valid       <= 1'b1;
                     wb_alu_result  <= in_alu_result;
                     wb_read_data   <= '0;
                     wb_pc_plus_4   <= in_pc_plus_4;
                     wb_pc_plus_imm <= in_pc_plus_imm;
                     wb_result_src  <= in_result_src;
                     wb_rd          <= in_rd;
                     wb_reg_write   <= in_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
                     wb_misaligned  <= 1'b0;
`endif
                  end
`ifdef MEM_MISALIGN_TRAP_EN
                  else if (w_mis) begin
                     r_state <= S_RESP;
                  end
`endif
                  else begin
                     r_state           <= S_REQ;
                     mem.mem_req_valid <= 1'b1;
                     mem.mem_req_addr  <= {in_alu_result[XLEN-1:2], 2'b00};
                     mem.mem_req_we    <= in_mem_write;
                     mem.mem_req_be    <= w_be;
                     mem.mem_req_wdata <= w_wdata;
                  end
               end
            end
            S_REQ: begin
               if (mem.mem_req_ready) begin
                  mem.mem_req_valid <= 1'b0;
                  r_state           <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem.mem_rsp_valid) begin
                  wb_valid       <= 1'b1;
                  wb_alu_result  <= r_alu;
                  wb_read_data   <= r_we ? '0 : f_ext(r_f3, r_a, mem.mem_rsp_rdata);
                  wb_pc_plus_4   <= r_pc4;
                  wb_pc_plus_imm <= r_pcimm;
                  wb_result_src  <= r_rsrc;
                  wb_rd          <= r_rd;
                  wb_reg_write   <= r_regw;
`ifdef MEM_MISALIGN_TRAP_EN
                  wb_misaligned  <= 1'b0;
`endif
                  r_state        <= S_IDLE;
               end
            end
`ifdef MEM_MISALIGN_TRAP_EN
            S_RESP: begin
               wb_valid       <= 1'b1;
               wb_alu_result  <= r_alu;
               wb_read_data   <= '0;
               wb_pc_plus_4   <= r_pc4;
               wb_pc_plus_imm <= r_pcimm;
               wb_result_src  <= r_rsrc;
               wb_rd          <= r_rd;
               wb_reg_write   <= 1'b0;
               wb_misaligned  <= 1'b1;
               r_state        <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage.
// ALU, loads, stores, stalls, reset.
`timescale 1ns/1ps

module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_stall;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [31:0] in_pc_plus_4;
  logic [31:0] in_pc_plus_imm;
  logic [1:0]  in_result_src;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_data;
  logic [31:0] wb_pc_plus_4;
  logic [31:0] wb_pc_plus_imm;
  logic [1:0]  wb_result_src;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        wb_misaligned;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    n_checks++;
    if (o !== e) begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, o, e);
    end
  endtask

  mem_access_stage_if #(.XLEN(32)) mif ();

  mem_access_stage #(.XLEN(32), .RSB(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_stall       (in_stall),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_funct3      (in_funct3),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_pc_plus_4   (in_pc_plus_4),
    .in_pc_plus_imm (in_pc_plus_imm),
    .in_result_src  (in_result_src),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .mem            (mif),
    .wb_valid       (wb_valid),
    .wb_alu_result  (wb_alu_result),
    .wb_read_data   (wb_read_data),
    .wb_pc_plus_4   (wb_pc_plus_4),
    .wb_pc_plus_imm (wb_pc_plus_imm),
    .wb_result_src  (wb_result_src),
    .wb_rd          (wb_rd),
`ifdef MEM_MISALIGN_TRAP_EN
    .wb_misaligned  (wb_misaligned),
`endif
    .wb_reg_write   (wb_reg_write)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] rdata,
    input logic [31:0] exp
  );
    in_valid      = 1'b1;
    in_mem_read   = 1'b1;
    in_mem_write  = 1'b0;
    in_funct3     = f3;
    in_alu_result = addr;
    in_rd         = 5'd7;
    in_result_src = 2'd1;
    in_reg_write  = 1'b1;
    step();
    in_valid = 1'b0;
    mif.mem_req_ready = 1'b1;
    chk("ld_req_valid", mif.mem_req_valid, 1'b1);
    chk("ld_req_addr", mif.mem_req_addr,
        {addr[31:2], 2'b00});
    chk("ld_req_be", mif.mem_req_be, 4'hF);
    chk("ld_req_we", mif.mem_req_we, 1'b0);
    chk("ld_stall", in_stall, 1'b1);
    step();
    mif.mem_req_ready = 1'b0;
    chk("ld_req_drop", mif.mem_req_valid, 1'b0);
    chk("ld_wb_early", wb_valid, 1'b0);
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = rdata;
    step();
    mif.mem_rsp_valid = 1'b0;
    chk("ld_wb_valid", wb_valid, 1'b1);
    chk("ld_rdata", wb_read_data, exp);
    chk("ld_rd", wb_rd, 5'd7);
    chk("ld_stall_done", in_stall, 1'b0);
    step();
    chk("ld_wb_pulse", wb_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_alu_result = '0;
    in_store_data = '0;
    in_funct3 = 3'b000;
    in_mem_read = 1'b0;
    in_mem_write = 1'b0;
    in_pc_plus_4 = '0;
    in_pc_plus_imm = '0;
    in_result_src = '0;
    in_rd = '0;
    in_reg_write = 1'b0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rsp_rdata = '0;
    repeat (2) step();
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_req_valid", mif.mem_req_valid, 1'b0);
    chk("rst_stall", in_stall, 1'b0);
    chk("rst_wb_alu", wb_alu_result, 32'h0);
    chk("rst_wb_regw", wb_reg_write, 1'b0);
    rst_n = 1'b1;
    step();

    in_valid = 1'b1;
    in_reg_write = 1'b1;
    in_rd = 5'd5;
    in_pc_plus_4 = 32'h0000_1004;
    for (int i = 1; i <= 3; i++) begin
      in_alu_result = i;
      step();
      chk("alu_wb_valid", wb_valid, 1'b1);
      chk("alu_result", wb_alu_result, 32'(i));
      chk("alu_stall", in_stall, 1'b0);
      chk("alu_rdata", wb_read_data, 32'h0);
    end
    in_valid = 1'b0;
    step();
    chk("alu_wb_idle", wb_valid, 1'b0);
    chk("alu_hold", wb_alu_result, 32'h3);
    chk("alu_pc4", wb_pc_plus_4, 32'h0000_1004);

    in_valid = 1'b1;
    in_mem_read = 1'b1;
    in_mem_write = 1'b1;
    in_alu_result = 32'h44;
    step();
    in_valid = 1'b0;
    in_mem_write = 1'b0;
    chk("rw_wb_valid", wb_valid, 1'b1);
    chk("rw_no_req", mif.mem_req_valid, 1'b0);
    chk("rw_alu", wb_alu_result, 32'h44);

    run_load(3'b000, 32'h0000_0103,
             32'h80FF_1234, 32'hFFFF_FF80);
    run_load(3'b100, 32'h0000_0103,
             32'h80FF_1234, 32'h0000_0080);
    run_load(3'b001, 32'h0000_0102,
             32'h80FF_1234, 32'hFFFF_80FF);
    run_load(3'b101, 32'h0000_0100,
             32'h80FF_9234, 32'h0000_9234);

    in_valid = 1'b1;
    in_mem_read = 1'b0;
    in_mem_write = 1'b1;
    in_funct3 = 3'b001;
    in_alu_result = 32'h0000_0202;
    in_store_data = 32'h0000_ABCD;
    in_reg_write = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mif.mem_req_ready = (i == 4);
      chk("sh_valid", mif.mem_req_valid, 1'b1);
      chk("sh_addr", mif.mem_req_addr, 32'h0000_0200);
      chk("sh_be", mif.mem_req_be, 4'b1100);
      chk("sh_wdata", mif.mem_req_wdata, 32'hABCD_ABCD);
      chk("sh_we", mif.mem_req_we, 1'b1);
      chk("sh_stall", in_stall, 1'b1);
      step();
    end
    mif.mem_req_ready = 1'b0;
    chk("sh_req_drop", mif.mem_req_valid, 1'b0);
    chk("sh_stall_wait", in_stall, 1'b1);
    mif.mem_rsp_valid = 1'b1;
    step();
    mif.mem_rsp_valid = 1'b0;
    chk("sh_wb_valid", wb_valid, 1'b1);
    chk("sh_stall_done", in_stall, 1'b0);

    in_valid = 1'b1;
    in_funct3 = 3'b000;
    in_alu_result = 32'h0000_0201;
    in_store_data = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    mif.mem_req_ready = 1'b1;
    chk("sb_be", mif.mem_req_be, 4'b0010);
    chk("sb_wdata", mif.mem_req_wdata, 32'h7878_7878);
    step();
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b1;
    step();
    mif.mem_rsp_valid = 1'b0;
    chk("sb_wb_valid", wb_valid, 1'b1);

    in_valid = 1'b1;
    in_mem_read = 1'b1;
    in_mem_write = 1'b0;
    in_funct3 = 3'b010;
    in_alu_result = 32'h0000_0040;
    in_rd = 5'd9;
    in_result_src = 2'd2;
    in_reg_write = 1'b1;
    step();
    in_valid = 1'b0;
    mif.mem_req_ready = 1'b1;
    step();
    mif.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lw_no_wb", wb_valid, 1'b0);
      chk("lw_stall", in_stall, 1'b1);
      step();
    end
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    mif.mem_rsp_valid = 1'b0;
    chk("lw_wb_valid", wb_valid, 1'b1);
    chk("lw_rdata", wb_read_data, 32'hDEAD_BEEF);
    chk("lw_rd", wb_rd, 5'd9);
    chk("lw_rsrc", wb_result_src, 2'd2);
    step();
    chk("lw_once", wb_valid, 1'b0);

    in_valid = 1'b1;
    in_alu_result = 32'h0000_0301;
    in_rd = 5'd3;
    step();
    in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_no_req", mif.mem_req_valid, 1'b0);
    chk("mis_stall", in_stall, 1'b1);
    chk("mis_wb_early", wb_valid, 1'b0);
    step();
    chk("mis_wb_valid", wb_valid, 1'b1);
    chk("mis_flag", wb_misaligned, 1'b1);
    chk("mis_regw", wb_reg_write, 1'b0);
    chk("mis_no_req2", mif.mem_req_valid, 1'b0);
    step();
    chk("mis_pulse", wb_valid, 1'b0);
`else
    mif.mem_req_ready = 1'b1;
    chk("mis_req", mif.mem_req_valid, 1'b1);
    chk("mis_addr", mif.mem_req_addr, 32'h0000_0300);
    step();
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 32'h0BAD_F00D;
    step();
    mif.mem_rsp_valid = 1'b0;
    chk("mis_wb_valid", wb_valid, 1'b1);
    chk("mis_rdata", wb_read_data, 32'h0BAD_F00D);
    step();
`endif

    in_valid = 1'b1;
    in_alu_result = 32'h0000_0010;
    step();
    in_valid = 1'b0;
    mif.mem_req_ready = 1'b1;
    step();
    mif.mem_req_ready = 1'b0;
    chk("rw_wait_stall", in_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", mif.mem_req_valid, 1'b0);
    chk("arst_wb_valid", wb_valid, 1'b0);
    chk("arst_stall", in_stall, 1'b0);
    step();
    rst_n = 1'b1;
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rsp_rdata = 32'h1111_2222;
    step();
    mif.mem_rsp_valid = 1'b0;
    chk("stale_rsp", wb_valid, 1'b0);
    chk("stale_stall", in_stall, 1'b0);
    step();
    chk("stale_rsp2", wb_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
